// File: rtl/counter_arb_pkg.sv
// -----------------------------------------------------------------------------
// counter_arb_pkg
// Shared definitions for the counter command arbiter:
//   arb_state_e : arbiter FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   CMD_DECR    : counter direction code for a decrement
//   CMD_INCR    : counter direction code for an increment
// -----------------------------------------------------------------------------
package counter_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic CMD_DECR = 1'b0;
  localparam logic CMD_INCR = 1'b1;

endpackage : counter_arb_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Picks the first asserted request at or
// after the pointer position, wrapping from N-1 back to 0.
// Ports:
//   req_i  [N-1:0]  request vector
//   ptr_i  [IW-1:0] search start position (always < N)
//   gnt_o  [N-1:0]  one-hot grant (all zero when no request)
//   idx_o  [IW-1:0] index of the granted request
//   any_o           at least one request is asserted
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int            cand_s;
  logic [IW-1:0] cidx_s;
  logic          hit_s;
  logic          found_s;

  // Walk the requests starting at ptr_i; the first hit wins and masks the rest.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    cand_s  = 0;
    cidx_s  = '0;
    hit_s   = 1'b0;
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand_s         = (int'(ptr_i) + i) % N;
      cidx_s         = IW'(cand_s);
      hit_s          = ~found_s & req_i[cidx_s];
      gnt_o[cidx_s]  = gnt_o[cidx_s] | hit_s;
      idx_o          = hit_s ? cidx_s : idx_o;
      found_s        = found_s | hit_s;
    end
  end

  assign any_o = |req_i;

endmodule : rr_pick

// File: rtl/counter_arbiter.sv
// -----------------------------------------------------------------------------
// counter_arbiter
// Round-robin arbiter sharing one up/down counter between NUM_REQ requesters.
// A granted command is issued as a one-cycle cnt_valid strobe, the counter's
// error flag is sampled ERR_LAT cycles later and returned with the requester
// ID as a one-cycle response. Failed commands are counted (saturating).
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   req_valid  per-requester command request
//   req_dir    per-requester direction (1 = increment, 0 = decrement)
//   req_ready  one-hot accept, combinational, only in IDLE
//   cnt_valid  command strobe to the counter
//   cnt_in     command direction to the counter (0 when cnt_valid is low)
//   cnt_err    error flag from the counter
//   rsp_valid  one-cycle response strobe
//   rsp_id     requester index of the response (0 when rsp_valid is low)
//   rsp_err    response error flag (0 when rsp_valid is low)
//   busy       high whenever the FSM is not in IDLE
//   err_clr    synchronous clear of err_count (wins over an increment)
//   err_count  saturating count of failed responses
// -----------------------------------------------------------------------------
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ERR_LAT   = 1,
  parameter int ERR_CNT_W = 8,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_dir,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 cnt_valid,
  output logic                 cnt_in,
  input  logic                 cnt_err,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_err,
  output logic                 busy,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Down-counter wide enough to hold ERR_LAT-1.
  localparam int WCW = (ERR_LAT > 1) ? $clog2(ERR_LAT) : 1;

  arb_state_e           state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       gid_q, gid_d;
  logic                 dir_q, dir_d;
  logic [WCW-1:0]       wait_q, wait_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic                 cnt_valid_q, cnt_valid_d;
  logic                 cnt_in_q, cnt_in_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   pick_gnt_s;
  logic [IDW-1:0]       pick_idx_s;
  logic                 pick_any_s;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_rr_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt_s),
    .idx_o (pick_idx_s),
    .any_o (pick_any_s)
  );

  // FSM next state, command latches, wait counter and combinational accept.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    dir_d     = dir_q;
    wait_d    = wait_q;
    rsp_err_d = 1'b0;
    req_ready = '0;

    case (state_q)
      IDLE: begin
        // Gating with rst keeps req_ready low while reset is held.
        if (rst && pick_any_s) begin
          req_ready = pick_gnt_s;
          gid_d     = pick_idx_s;
          dir_d     = req_dir[pick_idx_s] ? CMD_INCR : CMD_DECR;
          ptr_d     = (pick_idx_s == IDW'(NUM_REQ - 1)) ? '0 : pick_idx_s + IDW'(1);
          state_d   = ISSUE;
        end else begin
          req_ready = '0;
        end
      end
      ISSUE: begin
        wait_d  = WCW'(ERR_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // cnt_err is only looked at in the final WAIT cycle.
        if (wait_q == '0) begin
          rsp_err_d = cnt_err;
          state_d   = RESP;
        end else begin
          wait_d = wait_q - WCW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output register next values: strobes follow the upcoming state and the
  // qualified fields are forced to 0 whenever their strobe is low.
  always_comb begin
    cnt_valid_d = (state_d == ISSUE);
    cnt_in_d    = (state_d == ISSUE) ? dir_d : CMD_DECR;
    rsp_valid_d = (state_d == RESP);
    rsp_id_d    = (state_d == RESP) ? gid_q : '0;
    busy_d      = (state_d != IDLE);
    if (err_clr) begin
      err_d = '0;
    end else if (rsp_valid_q && rsp_err_q && (err_q != '1)) begin
      err_d = err_q + ERR_CNT_W'(1);
    end else begin
      err_d = err_q;
    end
  end

  // State, latches and registered outputs; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gid_q       <= '0;
      dir_q       <= CMD_DECR;
      wait_q      <= '0;
      err_q       <= '0;
      cnt_valid_q <= 1'b0;
      cnt_in_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      dir_q       <= dir_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      cnt_valid_q <= cnt_valid_d;
      cnt_in_q    <= cnt_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign cnt_valid = cnt_valid_q;
  assign cnt_in    = cnt_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign err_count = err_q;

endmodule : counter_arbiter

// File: tb/tb_counter_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_arbiter
// Self-checking bench for counter_arbiter (NUM_REQ=4, ERR_LAT=1, ERR_CNT_W=2).
// A table of commands with hand-derived expected grants, directions, errors
// and error counts is applied back to back; expected responses are queued at
// each handshake and popped by a response monitor. Hand-written sequences
// cover reset, idle error pulses, reset mid-command and round-robin rotation.
// -----------------------------------------------------------------------------
module tb_counter_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_dir;
  logic [3:0] req_ready;
  logic       cnt_valid;
  logic       cnt_in;
  logic       cnt_err;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic       rsp_err;
  logic       busy;
  logic       err_clr;
  logic [1:0] err_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] id;
    logic       err;
  } exp_t;

  typedef struct {
    logic [3:0] rv;
    logic [3:0] rd;
    logic       ce;
    logic       clr;
    int         exp_id;
    logic       exp_dir;
    logic       exp_err;
    int         exp_cnt;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[11];

  counter_arbiter #(
    .NUM_REQ   (4),
    .ERR_LAT   (1),
    .ERR_CNT_W (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_dir   (req_dir),
    .req_ready (req_ready),
    .cnt_valid (cnt_valid),
    .cnt_in    (cnt_in),
    .cnt_err   (cnt_err),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  // Response monitor: every response must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_id), 32'hffff_ffff);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
      end
    end
  end

  // One full command: handshake T, issue T+1, wait T+2, response T+3, idle T+4.
  task automatic run_cmd(input vec_t v);
    logic [3:0] oh;
    oh        = 4'b0001 << v.exp_id;
    req_valid = v.rv;
    req_dir   = v.rd;
    cnt_err   = 1'b0;
    settle();
    chk("grant", 32'(req_ready), 32'(oh));
    chk("busy_idle", 32'(busy), 32'd0);
    sb_q.push_back('{id: 2'(v.exp_id), err: v.exp_err});
    tick();
    cnt_err = ~v.ce;
    settle();
    chk("cnt_valid_issue", 32'(cnt_valid), 32'd1);
    chk("cnt_in_issue", 32'(cnt_in), 32'(v.exp_dir));
    chk("ready_held_off", 32'(req_ready), 32'd0);
    chk("busy_issue", 32'(busy), 32'd1);
    tick();
    cnt_err = v.ce;
    settle();
    chk("wait_quiet", 32'({cnt_valid, cnt_in, rsp_valid}), 32'd0);
    tick();
    cnt_err   = ~v.ce;
    req_valid = 4'b0000;
    err_clr   = v.clr;
    settle();
    chk("rsp_valid_resp", 32'(rsp_valid), 32'd1);
    chk("busy_resp", 32'(busy), 32'd1);
    tick();
    cnt_err = 1'b0;
    err_clr = 1'b0;
    settle();
    chk("after_resp_quiet", 32'({rsp_valid, rsp_id, rsp_err, busy}), 32'd0);
    chk("err_count", 32'(err_count), 32'(v.exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             rv       rd       ce    clr   id dir   err   cnt
    vecs[0]  = '{4'b0100, 4'b0100, 1'b0, 1'b0, 2, 1'b1, 1'b0, 0};
    vecs[1]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 3, 1'b0, 1'b0, 0};
    vecs[2]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0};
    vecs[3]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1};
    vecs[4]  = '{4'b0001, 4'b0001, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1};
    vecs[5]  = '{4'b1000, 4'b0000, 1'b1, 1'b0, 3, 1'b0, 1'b1, 2};
    vecs[6]  = '{4'b0110, 4'b0010, 1'b1, 1'b0, 1, 1'b1, 1'b1, 3};
    vecs[7]  = '{4'b0011, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 3};
    vecs[8]  = '{4'b0011, 4'b0011, 1'b0, 1'b0, 1, 1'b1, 1'b0, 3};
    vecs[9]  = '{4'b1100, 4'b1000, 1'b1, 1'b0, 2, 1'b0, 1'b1, 3};
    vecs[10] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 0, 1'b0, 1'b1, 0};

    // Reset held with every requester asking: all outputs stay 0.
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_dir   = 4'b0000;
    cnt_err   = 1'b0;
    err_clr   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      chk("reset_outputs",
          32'({req_ready, cnt_valid, cnt_in, rsp_valid, rsp_id, rsp_err, busy, err_count}),
          32'd0);
    end
    tick();
    rst = 1'b1;
    settle();
    chk("first_grant_after_reset", 32'(req_ready), 32'h1);
    // Requests withdrawn before the edge: no handshake, pointer stays at 0.
    req_valid = 4'b0000;
    #1;
    chk("ready_after_drop", 32'(req_ready), 32'd0);
    tick();

    // Table of back-to-back commands.
    for (int i = 0; i < 11; i++) begin
      run_cmd(vecs[i]);
    end

    // Error pulses while idle must not count or start anything.
    cnt_err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      chk("idle_err_ignored", 32'({busy, rsp_valid, req_ready}), 32'd0);
    end
    cnt_err = 1'b0;
    tick();
    settle();
    chk("idle_err_count", 32'(err_count), 32'd0);

    // Reset during WAIT aborts the command without a response.
    req_valid = 4'b0100;
    req_dir   = 4'b0100;
    settle();
    chk("midop_grant", 32'(req_ready), 32'h4);
    tick();
    settle();
    chk("midop_issue", 32'(cnt_valid), 32'd1);
    tick();
    req_valid = 4'b0000;
    settle();
    chk("midop_busy_wait", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("midop_abort", 32'({busy, cnt_valid, rsp_valid}), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("midop_no_rsp", 32'({rsp_valid, busy}), 32'd0);
      tick();
    end

    // Continuous requests from everyone: grants 0,1,2,3, four cycles apart.
    req_valid = 4'b1111;
    req_dir   = 4'b0101;
    for (int c = 0; c < 16; c++) begin
      logic [3:0] exp_rdy;
      exp_rdy = (c % 4 == 0) ? (4'b0001 << (c / 4)) : 4'b0000;
      settle();
      chk("rr_grant", 32'(req_ready), 32'(exp_rdy));
      chk("rr_cnt_valid", 32'(cnt_valid), (c % 4 == 1) ? 32'd1 : 32'd0);
      chk("rr_cnt_in", 32'(cnt_in), (c == 1 || c == 9) ? 32'd1 : 32'd0);
      if (c % 4 == 0) begin
        sb_q.push_back('{id: 2'(c / 4), err: 1'b0});
      end
      tick();
    end
    req_valid = 4'b0000;
    settle();
    chk("rr_end_idle", 32'({busy, req_ready}), 32'd0);
    tick();
    settle();

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_counter_arbiter
